// File: rtl/rv_dp_pkg.sv
// Shared encodings for the single-cycle RV32I datapath.
// Control-select values and the default reset PC.
package rv_dp_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/dp_regfile.sv
// 32x32 register file, two async read ports, one write port.
// x0 is hardwired to zero; reads during a write see the old value.
module dp_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic        we,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs [0:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/datapath.sv
// Single-cycle RV32I datapath: PC, regfile, immediate
// extender, ALU and writeback mux, driven by external control.
module datapath
  import rv_dp_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic            PCSrc,
  input  logic [1:0]      ResultSrc,
  input  logic            ALUSrc,
  input  logic [2:0]      ImmSrc,
  input  logic            RegWrite,
  input  logic [3:0]      ALUControl,
  input  logic [XLEN-1:0] ReadData,
  output logic [XLEN-1:0] PC,
  output logic            zero,
  output logic            comparison,
  output logic [XLEN-1:0] ALUResult,
  output logic [XLEN-1:0] WriteData
);

  logic [XLEN-1:0] src_a, src_b, rd2;
  logic [XLEN-1:0] imm_ext, result;
  logic [XLEN-1:0] pc_plus4, pc_target;
  logic [4:0]      shamt;
  logic            lt_s, lt_u;
  logic            unused_opcode;

  assign unused_opcode = ^instr[6:0];

  dp_regfile u_rf (
    .clk   (clk),
    .rst_n (rst),
    .ra1   (instr[19:15]),
    .ra2   (instr[24:20]),
    .wa    (instr[11:7]),
    .wd    (result),
    .we    (RegWrite),
    .rd1   (src_a),
    .rd2   (rd2)
  );

  always_comb begin
    imm_ext = '0;
    case (ImmSrc)
      IMM_I: imm_ext = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm_ext = {{20{instr[31]}}, instr[31:25],
                        instr[11:7]};
      IMM_B: imm_ext = {{19{instr[31]}}, instr[31], instr[7],
                        instr[30:25], instr[11:8], 1'b0};
      IMM_J: imm_ext = {{11{instr[31]}}, instr[31],
                        instr[19:12], instr[20],
                        instr[30:21], 1'b0};
      IMM_U: imm_ext = {instr[31:12], 12'b0};
      default: imm_ext = '0;
    endcase
  end

  assign src_b     = ALUSrc ? imm_ext : rd2;
  assign WriteData = rd2;
  assign shamt     = src_b[4:0];
  assign lt_s      = $signed(src_a) < $signed(src_b);
  assign lt_u      = src_a < src_b;

  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      ALU_ADD:  ALUResult = src_a + src_b;
      ALU_SUB:  ALUResult = src_a - src_b;
      ALU_AND:  ALUResult = src_a & src_b;
      ALU_OR:   ALUResult = src_a | src_b;
      ALU_XOR:  ALUResult = src_a ^ src_b;
      ALU_SLT:  ALUResult = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: ALUResult = {{(XLEN-1){1'b0}}, lt_u};
      ALU_SLL:  ALUResult = src_a << shamt;
      ALU_SRL:  ALUResult = src_a >> shamt;
      ALU_SRA:  ALUResult = $unsigned($signed(src_a) >>> shamt);
      default:  ALUResult = '0;
    endcase
  end

  assign zero       = (ALUResult == '0);
  assign comparison = (ALUControl == ALU_SLTU) ? lt_u : lt_s;

  assign pc_plus4  = PC + 32'd4;
  assign pc_target = PC + imm_ext;

  always_comb begin
    result = ALUResult;
    case (ResultSrc)
      RES_ALU: result = ALUResult;
      RES_MEM: result = ReadData;
      RES_PC4: result = pc_plus4;
      RES_IMM: result = imm_ext;
      default: result = ALUResult;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) PC <= RESET_PC;
    else      PC <= PCSrc ? pc_target : pc_plus4;
  end

endmodule

// File: tb/tb_datapath.sv
// Directed and random checks of the datapath against a
// behavioural model of registers, PC and ALU arithmetic.
module tb_datapath;
  import rv_dp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, ReadData;
  logic        PCSrc, ALUSrc, RegWrite;
  logic [1:0]  ResultSrc;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic [31:0] PC, ALUResult, WriteData;
  logic        zero, comparison;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_reg [32];
  logic [31:0] m_pc;
  logic [31:0] obs_alu, obs_wd;

  datapath dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .PCSrc      (PCSrc),
    .ResultSrc  (ResultSrc),
    .ALUSrc     (ALUSrc),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .ALUControl (ALUControl),
    .ReadData   (ReadData),
    .PC         (PC),
    .zero       (zero),
    .comparison (comparison),
    .ALUResult  (ALUResult),
    .WriteData  (WriteData)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(logic [4:0] rs2,
      logic [4:0] rs1, logic [4:0] rd);
    return {7'b0, rs2, rs1, 3'b0, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(logic [31:0] imm,
      logic [4:0] rs1, logic [4:0] rd);
    return {imm[11:0], rs1, 3'b0, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_s(logic [31:0] imm,
      logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(logic [31:0] imm,
      logic [4:0] rs2, logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b0,
            imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(logic [31:0] imm,
      logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  // Arithmetic view of the ALU: shifts via 64-bit widening.
  function automatic logic [31:0] ref_alu(logic [3:0] op,
      logic [31:0] a, logic [31:0] b);
    longint unsigned wa, ws;
    int sh;
    sh = int'(b[4:0]);
    wa = 64'(a);
    ws = {{32{a[31]}}, a};
    if (op == ALU_ADD)  return a + b;
    if (op == ALU_SUB)  return a + ~b + 32'd1;
    if (op == ALU_AND)  return a & b;
    if (op == ALU_OR)   return a | b;
    if (op == ALU_XOR)  return a ^ b;
    if (op == ALU_SLT)  return ($signed(a) < $signed(b)) ? 1 : 0;
    if (op == ALU_SLTU) return (a < b) ? 1 : 0;
    if (op == ALU_SLL)  return 32'(wa * (64'd1 << sh));
    if (op == ALU_SRL)  return 32'(wa / (64'd1 << sh));
    if (op == ALU_SRA)  return 32'(ws >> sh);
    return 32'd0;
  endfunction

  task automatic step(string tag, logic [31:0] ins,
      logic [31:0] imm, logic pcsrc, logic [1:0] rsrc,
      logic asrc, logic [2:0] isrc, logic we,
      logic [3:0] op, logic [31:0] rdata);
    logic [31:0] a, b, res, wb;
    logic        cmp;
    instr = ins; PCSrc = pcsrc; ResultSrc = rsrc;
    ALUSrc = asrc; ImmSrc = isrc; RegWrite = we;
    ALUControl = op; ReadData = rdata;
    a = m_reg[ins[19:15]];
    b = asrc ? imm : m_reg[ins[24:20]];
    res = ref_alu(op, a, b);
    cmp = (op == ALU_SLTU) ? (a < b)
                           : ($signed(a) < $signed(b));
    @(negedge clk);
    obs_alu = ALUResult;
    obs_wd  = WriteData;
    check({tag, ".alu"}, ALUResult, res);
    check({tag, ".zero"}, {31'b0, zero}, {31'b0, res == 0});
    check({tag, ".cmp"}, {31'b0, comparison}, {31'b0, cmp});
    check({tag, ".wdata"}, WriteData, m_reg[ins[24:20]]);
    case (rsrc)
      RES_MEM: wb = rdata;
      RES_PC4: wb = m_pc + 4;
      RES_IMM: wb = imm;
      default: wb = res;
    endcase
    @(posedge clk);
    if (we && ins[11:7] != 5'd0) m_reg[ins[11:7]] = wb;
    m_pc = pcsrc ? m_pc + imm : m_pc + 4;
    #1;
    check({tag, ".pc"}, PC, m_pc);
  endtask

  task automatic nop(string tag);
    step(tag, enc_i(0, 0, 0), 0, 0, RES_ALU, 1, IMM_I,
         0, ALU_ADD, 0);
  endtask

  task automatic addi(string tag, logic [4:0] rd,
      logic [4:0] rs1, logic [31:0] imm);
    step(tag, enc_i(imm, rs1, rd), imm, 0, RES_ALU, 1, IMM_I,
         1, ALU_ADD, 0);
  endtask

  task automatic rop(string tag, logic [3:0] op,
      logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    step(tag, enc_r(rs2, rs1, rd), 0, 0, RES_ALU, 0, IMM_I,
         1, op, 0);
  endtask

  initial begin
    logic [31:0] p, imm, ins, rv;
    logic [4:0]  r1, r2, rd;
    int          fmt;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_pc = 32'd0;
    rst = 1'b0;
    instr = enc_r(3, 2, 1); PCSrc = 0; ResultSrc = RES_ALU;
    ALUSrc = 0; ImmSrc = IMM_I; RegWrite = 1;
    ALUControl = ALU_ADD; ReadData = 0;
    #2;
    check("rst.pc", PC, 32'd0);
    check("rst.alu", ALUResult, 32'd0);
    @(posedge clk); #1;
    check("rst.hold", PC, 32'd0);
    rst = 1'b1;

    nop("pc4"); nop("pc8"); nop("pc12");
    check("pc12.abs", PC, 32'd12);

    addi("addi2", 2, 0, 5);
    addi("addi3", 3, 0, 10);
    rop("add1", ALU_ADD, 1, 2, 3);
    check("add1.k", obs_alu, 32'd15);
    rop("sub4", ALU_SUB, 4, 2, 3);
    check("sub4.k", obs_alu, 32'hFFFF_FFFB);
    addi("addi5", 5, 2, 32'hFFFF_FFFD);
    check("addi5.k", obs_alu, 32'd2);

    step("lw6", enc_i(0, 2, 6), 0, 0, RES_MEM, 1, IMM_I, 1,
         ALU_ADD, 32'hDEAD_BEEF);
    check("lw6.k", obs_alu, 32'd5);
    rop("add9", ALU_ADD, 9, 6, 0);
    check("add9.k", obs_alu, 32'hDEAD_BEEF);

    step("sw", enc_s(0, 1, 2), 0, 0, RES_ALU, 1, IMM_S, 0,
         ALU_ADD, 32'h1234_5678);
    check("sw.addr", obs_alu, 32'd5);
    check("sw.data", obs_wd, 32'd15);
    step("lw8", enc_i(0, 2, 8), 0, 0, RES_MEM, 1, IMM_I, 1,
         ALU_ADD, 32'd15);
    rop("add11", ALU_ADD, 11, 8, 0);
    check("x8.k", obs_alu, 32'd15);

    p = PC;
    step("beq", enc_b(16, 2, 2), 16, 1, RES_ALU, 0, IMM_B, 0,
         ALU_SUB, 0);
    check("beq.k", PC, p + 32'd16);
    rop("sub7", ALU_SUB, 7, 2, 2);
    check("sub7.k", obs_alu, 32'd0);
    addi("wx0", 0, 0, 7);
    rop("rdx0", ALU_OR, 10, 0, 0);
    check("x0.k", obs_alu, 32'd0);

    step("jal", enc_j(32'hFFFF_FFF8, 1), 32'hFFFF_FFF8, 1,
         RES_PC4, 1, IMM_J, 1, ALU_ADD, 0);
    step("lui", {20'hABCDE, 5'd12, 7'h37}, 32'hABCD_E000, 0,
         RES_IMM, 1, IMM_U, 1, ALU_ADD, 0);
    rop("sra", ALU_SRA, 13, 12, 2);
    rop("sltu", ALU_SLTU, 14, 12, 2);
    rop("slt", ALU_SLT, 15, 12, 2);

    for (int n = 0; n < 120; n++) begin
      r1 = 5'($urandom); r2 = 5'($urandom);
      rd = 5'($urandom); rv = $urandom;
      fmt = $urandom_range(0, 7);
      case (fmt)
        0: begin
          imm = {{20{rv[11]}}, rv[11:0]};
          ins = enc_i(imm, r1, rd);
        end
        1: begin
          imm = {{20{rv[11]}}, rv[11:0]};
          ins = enc_s(imm, r2, r1);
        end
        2: begin
          imm = {{19{rv[12]}}, rv[12:1], 1'b0};
          ins = enc_b(imm, r2, r1);
        end
        3: begin
          imm = {{11{rv[20]}}, rv[20:1], 1'b0};
          ins = enc_j(imm, rd);
        end
        4: begin
          imm = {rv[31:12], 12'b0};
          ins = {rv[31:12], rd, 7'h37};
        end
        default: begin
          imm = 32'd0;
          ins = enc_r(r2, r1, rd);
        end
      endcase
      step("rnd", ins, imm, ($urandom_range(0, 3) == 0),
           2'($urandom), 1'($urandom), 3'(fmt),
           1'($urandom), 4'($urandom), $urandom);
    end

    // Asynchronous reset between edges with a write pending.
    addi("pre", 2, 0, 5);
    instr = enc_r(2, 2, 1); PCSrc = 0; ResultSrc = RES_ALU;
    ALUSrc = 0; RegWrite = 1; ALUControl = ALU_ADD;
    #3 rst = 1'b0;
    #1;
    check("mid.pc", PC, 32'd0);
    check("mid.alu", ALUResult, 32'd0);
    @(posedge clk); #1;
    check("mid.hold", PC, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_pc = 32'd0;
    rop("post", ALU_ADD, 3, 2, 1);
    check("post.k", obs_alu, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
